// File: rtl/mcdiv_pkg.sv
// Shared types and constants for the iterative restoring divider.
package mcdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam int unsigned MAX_WIDTH = 64;

  // Quotient returned on divide-by-zero, sliced down to the instance width.
  localparam logic [MAX_WIDTH-1:0] DIV_ZERO_QUO = '1;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import mcdiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             unused_hi;

  assign shifted  = {rem, dvd_bit};
  assign trial    = {1'b0, shifted} - {2'b00, divisor};
  assign q_bit    = ~trial[WIDTH+1];
  // Partial remainder stays below the divisor, so the top bits are never needed.
  assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign unused_hi = trial[WIDTH] ^ shifted[WIDTH];

endmodule

// File: rtl/multi_cycle_div.sv
// Iterative signed/unsigned radix-2 divider with busy/done handshake and flush cancel.
module multi_cycle_div
  import mcdiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic             cancel,
  input  logic             flag_unsigned,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      CW       = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] ZERO_QUO = DIV_ZERO_QUO[WIDTH-1:0];

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dsr_q, dsr_d, rem_q, rem_d, quo_q, quo_d;
  logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, zero_q, zero_d;
  logic [WIDTH-1:0] quotient_d, remainder_d;
  logic             div_zero_d, busy_d, done_d;

  logic [WIDTH-1:0] abs1_c, abs2_c, step_rem_c;
  logic             step_bit_c, accept_c;

  assign abs1_c   = (!flag_unsigned && operand1[WIDTH-1]) ? (~operand1 + WIDTH'(1)) : operand1;
  assign abs2_c   = (!flag_unsigned && operand2[WIDTH-1]) ? (~operand2 + WIDTH'(1)) : operand2;
  assign accept_c = start && !cancel;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .dvd_bit  (dvd_q[WIDTH-1]),
    .divisor  (dsr_q),
    .rem_next (step_rem_c),
    .q_bit    (step_bit_c)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept_c) state_d = (abs2_c == '0) ? FIX : CALC;
      CALC: begin
        if (cancel)              state_d = IDLE;
        else if (count_q == '0)  state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d     = count_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    zero_d      = zero_q;
    quotient_d  = quotient;
    remainder_d = remainder;
    div_zero_d  = div_zero;
    busy_d      = busy;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          dvd_d     = abs1_c;
          dsr_d     = abs2_c;
          quo_d     = '0;
          neg_quo_d = !flag_unsigned && (operand1[WIDTH-1] ^ operand2[WIDTH-1]);
          neg_rem_d = !flag_unsigned && operand1[WIDTH-1];
          zero_d    = (abs2_c == '0);
          count_d   = CW'(WIDTH - 1);
          busy_d    = 1'b1;
          // Divide-by-zero reuses the remainder sign fix to hand back the raw dividend.
          rem_d     = (abs2_c == '0) ? abs1_c : '0;
        end
      end
      CALC: begin
        if (cancel) begin
          busy_d = 1'b0;
        end else begin
          rem_d   = step_rem_c;
          quo_d   = {quo_q[WIDTH-2:0], step_bit_c};
          dvd_d   = {dvd_q[WIDTH-2:0], 1'b0};
          count_d = count_q - CW'(1);
        end
      end
      FIX: begin
        busy_d = 1'b0;
        if (!cancel) begin
          quotient_d  = zero_q ? ZERO_QUO : (neg_quo_q ? (~quo_q + WIDTH'(1)) : quo_q);
          remainder_d = neg_rem_q ? (~rem_q + WIDTH'(1)) : rem_q;
          div_zero_d  = zero_q;
          done_d      = 1'b1;
        end
      end
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q   <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      count_q   <= count_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
      quotient  <= quotient_d;
      remainder <= remainder_d;
      div_zero  <= div_zero_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_multi_cycle_div.sv
// Directed bench for multi_cycle_div at WIDTH=32 with hand-computed results.
module tb_multi_cycle_div;

  localparam int unsigned W = 32;

  logic         clock;
  logic         resetn;
  logic         start;
  logic         cancel;
  logic         flag_unsigned;
  logic [W-1:0] operand1;
  logic [W-1:0] operand2;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;
  logic         busy;
  logic         done;

  int n_checks;
  int n_fail;

  multi_cycle_div #(.WIDTH(W)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .start         (start),
    .cancel        (cancel),
    .flag_unsigned (flag_unsigned),
    .operand1      (operand1),
    .operand2      (operand2),
    .quotient      (quotient),
    .remainder     (remainder),
    .div_zero      (div_zero),
    .busy          (busy),
    .done          (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Wait for done from cycle start_cyc, counting busy cycles; capped so it always ends.
  task automatic wait_done(input int start_cyc, output int cyc, output int bcnt);
    cyc  = start_cyc;
    bcnt = 0;
    while (!done && cyc < 60) begin
      if (busy) bcnt++;
      tick();
      cyc++;
    end
  endtask

  // Issue a one-cycle start, scramble the operands, and check the result in the done cycle.
  task automatic do_div(input string tag, input logic uns, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic ez, input int elat);
    int cyc, bcnt;
    flag_unsigned = uns;
    operand1      = a;
    operand2      = b;
    start         = 1'b1;
    tick();
    start         = 1'b0;
    flag_unsigned = ~uns;
    operand1      = ~a;
    operand2      = ~b;
    wait_done(1, cyc, bcnt);
    check_eq({tag, "_lat"},  64'(cyc), 64'(elat));
    check_eq({tag, "_q"},    64'(quotient), 64'(eq));
    check_eq({tag, "_r"},    64'(remainder), 64'(er));
    check_eq({tag, "_dz"},   64'(div_zero), 64'(ez));
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_bcyc"}, 64'(bcnt), 64'(elat - 1));
  endtask

  initial begin
    int cyc, bcnt, dcnt;
    n_checks      = 0;
    n_fail        = 0;
    resetn        = 1'b0;
    start         = 1'b0;
    cancel        = 1'b0;
    flag_unsigned = 1'b0;
    operand1      = '0;
    operand2      = '0;
    #12;
    check_eq("rst_q", 64'(quotient), 64'd0);
    check_eq("rst_r", 64'(remainder), 64'd0);
    check_eq("rst_flags", 64'({div_zero, busy, done}), 64'd0);
    resetn = 1'b1;
    tick();

    do_div("u100_7", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
    tick();
    check_eq("pulse_done", 64'(done), 64'd0);
    check_eq("hold_q", 64'(quotient), 64'd14);

    do_div("s_m7_2",  1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34);
    do_div("s_7_m2",  1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 34);
    do_div("u_max_2", 1'b1, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, 34);
    do_div("s_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34);
    do_div("dz_5",    1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2);
    do_div("dz_m5",   1'b0, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 2);
    do_div("s_6_3",   1'b0, 32'd6, 32'd3, 32'd2, 32'd0, 1'b0, 34);

    // Start while busy must not restart or queue.
    flag_unsigned = 1'b1;
    operand1 = 32'd100;
    operand2 = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    operand1 = '0;
    operand2 = '0;
    repeat (3) tick();
    operand1 = 32'd9;
    operand2 = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(5, cyc, bcnt);
    check_eq("ign_lat", 64'(cyc), 64'd34);
    check_eq("ign_q", 64'(quotient), 64'd14);
    check_eq("ign_r", 64'(remainder), 64'd2);
    tick();
    check_eq("ign_noq", 64'(done), 64'd0);

    // Cancel mid-CALC: outputs untouched, no done.
    operand1 = 32'd100;
    operand2 = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check_eq("can_busy", 64'(busy), 64'd0);
    check_eq("can_done", 64'(done), 64'd0);
    check_eq("can_q", 64'(quotient), 64'd14);
    check_eq("can_r", 64'(remainder), 64'd2);
    check_eq("can_dz", 64'(div_zero), 64'd0);
    do_div("after_can", 1'b1, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);

    // Cancel coinciding with the FIX edge wins.
    operand1 = 32'd100;
    operand2 = 32'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (32) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check_eq("canfix_done", 64'(done), 64'd0);
    check_eq("canfix_busy", 64'(busy), 64'd0);
    check_eq("canfix_q", 64'(quotient), 64'd3);

    // Start together with cancel in IDLE is ignored.
    start = 1'b1;
    cancel = 1'b1;
    tick();
    start = 1'b0;
    cancel = 1'b0;
    check_eq("stcan_busy", 64'(busy), 64'd0);
    tick();
    check_eq("stcan_done", 64'(done), 64'd0);

    // Asynchronous reset mid-divide.
    operand1 = 32'd50;
    operand2 = 32'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    #1 resetn = 1'b0;
    #1;
    check_eq("arst_q", 64'(quotient), 64'd0);
    check_eq("arst_r", 64'(remainder), 64'd0);
    check_eq("arst_flags", 64'({div_zero, busy, done}), 64'd0);
    #3 resetn = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) dcnt++;
    end
    check_eq("arst_nodone", 64'(dcnt), 64'd0);

    // Back-to-back: second start issued in the done cycle of the first.
    do_div("b2b_1", 1'b1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
    do_div("b2b_2", 1'b1, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 34);
    tick();
    check_eq("b2b_pulse", 64'(done), 64'd0);
    check_eq("b2b_hold", 64'(quotient), 64'd100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
